// File: rtl/multibyte_addsub_seq_if.sv
// Host-side bus of the multi-byte add/sub sequencer: operation request in, wide result out.
// Handshake: start is taken at any rising edge where busy=0 (idle or done); done is a
// one-cycle result strobe with no backpressure, and q/cout/zero hold until the next accepted start.
interface multibyte_addsub_seq_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         isSub;
    logic         isCarry;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic         cout;
    logic         zero;

    modport master (
        output start, a, b, isSub, isCarry, cin,
        input  busy, done, q, cout, zero
    );

    modport slave (
        input  start, a, b, isSub, isCarry, cin,
        output busy, done, q, cout, zero
    );
endinterface

// File: rtl/multibyte_addsub_seq.sv
// Sequences an NBYTES-wide add/subtract through an external 8-bit addsub stage,
// one byte per cycle LSB first, chaining carry and assembling result, carry and zero flag.
module multibyte_addsub_seq #(
    parameter int NBYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multibyte_addsub_seq_if.slave       bus,
    output logic [7:0]                  aluA,
    output logic [7:0]                  aluB,
    output logic                        aluSub,
    output logic                        aluCarry,
    output logic                        aluCin,
    input  logic [7:0]                  aluQ,
    input  logic                        aluCout,
    output logic [1:0]                  dbg_state
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_r, b_r, q_r, q_nxt;
    logic          sub_r, carry_r, cin_r, chain, cout_r, zero_r;
    logic          accept, last;

    assign accept = bus.start && ((state == IDLE) || (state == DONE));
    assign last   = (state == RUN) && (idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (idx == LAST) state_nxt = DONE;
            DONE:    state_nxt = bus.start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result with the current slice replaced by the ALU output; the zero flag looks at this.
    always_comb begin
        q_nxt = q_r;
        q_nxt[{idx, 3'b000} +: 8] = aluQ;
    end

    // idx and chain freeze on the final slice so the ALU drive holds its last value afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            cin_r   <= 1'b0;
            chain   <= 1'b0;
            q_r     <= '0;
            cout_r  <= 1'b0;
            zero_r  <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            a_r     <= bus.a;
            b_r     <= bus.b;
            sub_r   <= bus.isSub;
            carry_r <= bus.isCarry;
            cin_r   <= bus.cin;
        end else if (state == RUN) begin
            q_r <= q_nxt;
            if (last) begin
                cout_r <= aluCout;
                zero_r <= (q_nxt == '0);
            end else begin
                chain <= aluCout;
                idx   <= idx + 1'b1;
            end
        end
    end

    assign aluA      = a_r[{idx, 3'b000} +: 8];
    assign aluB      = b_r[{idx, 3'b000} +: 8];
    assign aluSub    = sub_r;
    assign aluCarry  = (idx == '0) ? carry_r : 1'b1;
    assign aluCin    = (idx == '0) ? cin_r : chain;

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.q     = q_r;
    assign bus.cout  = cout_r;
    assign bus.zero  = zero_r;
    assign dbg_state = state;
endmodule

// File: tb/tb_multibyte_addsub_seq.sv
// Bench for multibyte_addsub_seq: models the 8-bit addsub stage, drives directed and random
// operations, and scores results against a whole-word arithmetic reference.
module tb_multibyte_addsub_seq;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;
    localparam int RW     = W + 2;

    // clock / reset
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    multibyte_addsub_seq_if #(.NBYTES(NBYTES)) bus();

    logic [7:0] aluA, aluB, aluQ;
    logic       aluSub, aluCarry, aluCin, aluCout;
    logic [1:0] dbg_state;

    multibyte_addsub_seq #(.NBYTES(NBYTES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .aluA     (aluA),
        .aluB     (aluB),
        .aluSub   (aluSub),
        .aluCarry (aluCarry),
        .aluCin   (aluCin),
        .aluQ     (aluQ),
        .aluCout  (aluCout),
        .dbg_state(dbg_state)
    );

    // Behavioural 8-bit addsub stage: default carry-in is 1 for subtract, 0 for add.
    logic [7:0] alu_bx;
    logic       alu_c0;
    logic [8:0] alu_sum;
    always_comb begin
        alu_bx  = aluSub ? ~aluB : aluB;
        alu_c0  = aluCarry ? aluCin : aluSub;
        alu_sum = {1'b0, aluA} + {1'b0, alu_bx} + {8'b0, alu_c0};
        aluQ    = alu_sum[7:0];
        aluCout = alu_sum[8];
    end

    // scoreboard
    int errors = 0;
    int checks = 0;
    logic [RW-1:0] exp_q[$];
    int unsigned   exp_cyc[$];
    logic [RW-1:0] last_res = '0;
    int            busy_cnt = 0;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Reference: whole-word arithmetic, packed as {cout, zero, q}.
    function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s, input logic c, input logic ci);
        logic [W-1:0] bx;
        logic         c0;
        logic [W:0]   full;
        bx   = s ? ~b : b;
        c0   = c ? ci : s;
        full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, c0};
        return {full[W], (full[W-1:0] == '0), full[W-1:0]};
    endfunction

    // monitor
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cyc.delete();
            last_res = '0;
            busy_cnt = 0;
        end else if (bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                logic [RW-1:0] e;
                int unsigned   ec;
                e  = exp_q.pop_front();
                ec = exp_cyc.pop_front();
                check("result", 64'({bus.cout, bus.zero, bus.q}), 64'(e));
                check("done_latency", 64'(cyc), 64'(ec));
                check("busy_cycles", 64'(busy_cnt), 64'(NBYTES));
                last_res = e;
            end
            busy_cnt = 0;
        end else if (bus.busy) begin
            busy_cnt++;
            check("flags_hold_run", 64'({bus.cout, bus.zero}), 64'(last_res[RW-1 -: 2]));
        end else begin
            check("result_hold_idle", 64'({bus.cout, bus.zero, bus.q}), 64'(last_res));
        end
    end

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic c, input logic ci);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 50) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.a     = $urandom;
            bus.b     = $urandom;
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL start_wait_timeout: got busy=1 for %0d cycles expected at most %0d", n, NBYTES);
            return;
        end
        bus.a       = a;
        bus.b       = b;
        bus.isSub   = s;
        bus.isCarry = c;
        bus.cin     = ci;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        check("start_accepted", 64'(bus.busy), 64'd1);
        exp_q.push_back(model(a, b, s, c, ci));
        exp_cyc.push_back(cyc + NBYTES);
    endtask

    // Watches the per-slice ALU drive while start and operands are scrambled.
    task automatic chain_check(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] av;
        av = a;
        issue(a, b, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NBYTES; i++) begin
            @(negedge clk);
            check("alu_cin_slice", 64'(aluCin), (i == 0) ? 64'd0 : 64'd1);
            check("alu_carry_slice", 64'(aluCarry), (i == 0) ? 64'd0 : 64'd1);
            check("alu_a_slice", 64'(aluA), 64'(av[i*8 +: 8]));
            bus.start = 1'($urandom_range(0, 1));
            bus.a     = $urandom;
            bus.b     = $urandom;
        end
        idle(1);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           n;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        bus.isSub = 1'b0; bus.isCarry = 1'b0; bus.cin = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'({bus.q, bus.cout, bus.zero, bus.busy, bus.done}), 64'd0);
        check("reset_alu_drive", 64'({aluA, aluB, aluSub, aluCarry, aluCin}), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // carry ripple, then idle hold
        issue(32'h0000_01FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        idle(3);
        // borrow-free subtract followed back-to-back by a borrowing one
        issue(32'h0000_0200, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        issue(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        idle(2);
        // explicit carry-in, sub to zero and add to all-ones
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1);
        idle(1);
        // carry propagates through every upper slice
        chain_check(32'h7FFF_FFFF, 32'h0000_0001);

        // asynchronous reset mid-operation (idx=1)
        issue(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_reset_outputs", 64'({bus.q, bus.cout, bus.zero, bus.busy, bus.done}), 64'd0);
        check("midop_reset_alu_drive", 64'({aluA, aluB, aluSub, aluCarry, aluCin}), 64'd0);
        check("midop_reset_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        rst_n = 1'b1;
        idle(1);
        issue(32'd106, 32'd44, 1'b0, 1'b0, 1'b0);
        idle(2);

        // random operations, mixing back-to-back and gaps
        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        // drain
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
